// File: rtl/hash_chain_seq.sv
// hash_chain_seq: block sequencer that chains digests of the hash core.
// Define HASH_LEN_BLOCK_EN to append a length block after the last block.
`timescale 1ns/1ps

module hash_chain_seq #(
    parameter logic [7:0] IV_A  = 8'h67,
    parameter logic [7:0] IV_B  = 8'hEF,
    parameter logic [7:0] IV_C  = 8'h98,
    parameter logic [7:0] IV_D  = 8'h10,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [31:0]      blk_data,
    input  logic             blk_last,
    output logic [31:0]      core_msg,
    output logic [7:0]       a0,
    output logic [7:0]       b0,
    output logic [7:0]       c0,
    output logic [7:0]       d0,
    output logic             core_start,
    input  logic             core_done,
    input  logic [31:0]      digest_in,
    output logic             hash_valid,
    input  logic             hash_ready,
    output logic [31:0]      hash_out,
    output logic [CNT_W-1:0] blk_count,
    output logic             err
);

    localparam logic [31:0] IV = {IV_A, IV_B, IV_C, IV_D};

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        ACCUM,
        OUT
    } state_t;

    state_t            state;
    logic [31:0]       h;
    logic [31:0]       msg_reg;
    logic [31:0]       dig_reg;
    logic              last_reg;
    logic [31:0]       h_sum;
    logic [CNT_W-1:0]  cnt_next;

    // Lanes add independently; the 8-bit sums drop their carry.
    always_comb begin
        h_sum = '0;
        h_sum[31:24] = h[31:24] + dig_reg[31:24];
        h_sum[23:16] = h[23:16] + dig_reg[23:16];
        h_sum[15:8]  = h[15:8]  + dig_reg[15:8];
        h_sum[7:0]   = h[7:0]   + dig_reg[7:0];
    end

    always_comb begin
        cnt_next = blk_count;
        if (!(&blk_count)) begin
            cnt_next = blk_count + 1'b1;
        end
    end

`ifdef HASH_LEN_BLOCK_EN
    logic        len_phase;
    logic [15:0] len16;

    generate
        if (CNT_W >= 16) begin : g_len_trunc
            assign len16 = cnt_next[15:0];
        end else begin : g_len_ext
            assign len16 = {{(16-CNT_W){1'b0}}, cnt_next};
        end
    endgenerate
`endif

    assign blk_ready = (state == IDLE);
    assign core_msg  = msg_reg;
    assign a0        = h[31:24];
    assign b0        = h[23:16];
    assign c0        = h[15:8];
    assign d0        = h[7:0];
    assign hash_out  = h;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h          <= IV;
            msg_reg    <= '0;
            dig_reg    <= '0;
            last_reg   <= 1'b0;
            blk_count  <= '0;
            core_start <= 1'b0;
            hash_valid <= 1'b0;
            err        <= 1'b0;
`ifdef HASH_LEN_BLOCK_EN
            len_phase  <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            // A done pulse outside WAIT is flagged but never consumed.
            if (core_done && state != WAIT) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        msg_reg    <= blk_data;
                        last_reg   <= blk_last;
                        core_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        dig_reg <= digest_in;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    h <= h_sum;
`ifdef HASH_LEN_BLOCK_EN
                    if (len_phase) begin
                        len_phase  <= 1'b0;
                        hash_valid <= 1'b1;
                        state      <= OUT;
                    end else begin
                        blk_count <= cnt_next;
                        if (last_reg) begin
                            msg_reg    <= {16'h8000, len16};
                            len_phase  <= 1'b1;
                            core_start <= 1'b1;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
`else
                    blk_count <= cnt_next;
                    if (last_reg) begin
                        hash_valid <= 1'b1;
                        state      <= OUT;
                    end else begin
                        state <= IDLE;
                    end
`endif
                end
                OUT: begin
                    if (hash_ready) begin
                        h          <= IV;
                        blk_count  <= '0;
                        hash_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_chain_seq.sv
// tb_hash_chain_seq: scoreboard bench for hash_chain_seq.
// Honours HASH_LEN_BLOCK_EN when the design is built with it.
`timescale 1ns/1ps

module tb_hash_chain_seq;

    localparam logic [31:0] IV = 32'h67EF9810;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blk_valid = 1'b0;
    logic [31:0] blk_data = '0;
    logic        blk_last = 1'b0;
    logic        hash_ready = 1'b0;
    logic        done_m = 1'b0;
    logic        spur = 1'b0;
    logic [31:0] dig_m = '0;
    logic        core_done;
    logic        blk_ready;
    logic [31:0] core_msg;
    logic [7:0]  a0, b0, c0, d0;
    logic        core_start;
    logic        hash_valid;
    logic [31:0] hash_out;
    logic [15:0] blk_count;
    logic        err;

    assign core_done = done_m | spur;

    hash_chain_seq dut (
        .clk(clk),
        .rst(rst),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data(blk_data),
        .blk_last(blk_last),
        .core_msg(core_msg),
        .a0(a0),
        .b0(b0),
        .c0(c0),
        .d0(d0),
        .core_start(core_start),
        .core_done(core_done),
        .digest_in(dig_m),
        .hash_valid(hash_valid),
        .hash_ready(hash_ready),
        .hash_out(hash_out),
        .blk_count(blk_count),
        .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] q_msg[$];
    logic [31:0] q_chain[$];
    logic [31:0] q_dig[$];
    logic [47:0] q_hash[$];

    logic [31:0] mh = IV;
    int          mcnt = 0;
    int          n_exp = 0;
    int          n_starts = 0;
    int          fix_delay = 0;
    logic        no_hold = 1'b0;
    logic        hold_rdy = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fold(logic [31:0] hv, logic [31:0] d);
        logic [31:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = int'(hv[8*i +: 8]) + int'(d[8*i +: 8]);
            r[8*i +: 8] = 8'(s % 256);
        end
        return r;
    endfunction

    task automatic drive(logic [31:0] data, logic last);
        int t;
        t = 0;
        @(negedge clk);
        while (!blk_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("blk_ready_timeout", 32'd0, 32'd1);
        blk_valid = 1'b1;
        blk_data  = data;
        blk_last  = last;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
    endtask

    task automatic issue(logic [31:0] data, logic last, logic [31:0] dig);
        logic [31:0] ld;
        ld = $urandom;
        q_msg.push_back(data);
        q_chain.push_back(mh);
        q_dig.push_back(dig);
        n_exp++;
        mh = fold(mh, dig);
        if (mcnt < 65535) mcnt++;
        if (last) begin
`ifdef HASH_LEN_BLOCK_EN
            q_msg.push_back({16'h8000, 16'(mcnt)});
            q_chain.push_back(mh);
            q_dig.push_back(ld);
            n_exp++;
            mh = fold(mh, ld);
`endif
            q_hash.push_back({mh, 16'(mcnt)});
            mh = IV;
            mcnt = 0;
        end
        drive(data, last);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_hash.size() != 0 || q_dig.size() != 0 || !blk_ready)
               && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    // Core model: consumes expected block, answers with the queued digest.
    initial begin
        logic [31:0] em, ec, d;
        int dl;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                n_starts++;
                chk("blk_ready_start", 32'(blk_ready), 32'd0);
                if (q_msg.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                end else begin
                    em = q_msg.pop_front();
                    ec = q_chain.pop_front();
                    d  = q_dig.pop_front();
                    chk("core_msg", core_msg, em);
                    chk("chain_in", {a0, b0, c0, d0}, ec);
                    dl = (fix_delay != 0) ? fix_delay : $urandom_range(1, 4);
                    repeat (dl) begin
                        @(negedge clk);
                        chk("start_pulse", 32'(core_start), 32'd0);
                        if (!no_hold) begin
                            chk("msg_hold", core_msg, em);
                            chk("chain_hold", {a0, b0, c0, d0}, ec);
                            chk("blk_ready_wait", 32'(blk_ready), 32'd0);
                        end
                    end
                    dig_m  = d;
                    done_m = 1'b1;
                    @(negedge clk);
                    done_m = 1'b0;
                    if (!no_hold) begin
                        chk("blk_ready_accum", 32'(blk_ready), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            hash_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: every accepted hash is checked against the scoreboard.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (hash_valid && hash_ready && !rst) begin
                if (q_hash.size() == 0) begin
                    chk("unexpected_hash", 32'd1, 32'd0);
                end else begin
                    e = q_hash.pop_front();
                    chk("hash_out", hash_out, e[47:16]);
                    chk("blk_count", 32'(blk_count), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] h0;
        int t;
        int nb;
        int ns0;
        repeat (3) @(negedge clk);
        chk("rst_blk_ready", 32'(blk_ready), 32'd1);
        chk("rst_chain", {a0, b0, c0, d0}, IV);
        chk("rst_hash_out", hash_out, IV);
        chk("rst_core_msg", core_msg, 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_hash_valid", 32'(hash_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_blk_count", 32'(blk_count), 32'd0);
        rst = 1'b0;

        issue(32'hDEADBEEF, 1'b1, 32'h01020304);
        issue($urandom, 1'b1, 32'h991168F0);
        issue($urandom, 1'b0, 32'h11111111);
        issue($urandom, 1'b1, 32'h22222222);
        drain();

        hold_rdy = 1'b1;
        issue($urandom, 1'b1, $urandom);
        t = 0;
        while (!hash_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", 32'(hash_valid), 32'd1);
        h0 = hash_out;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(hash_valid), 32'd1);
            chk("bp_stable", hash_out, h0);
            chk("bp_blk_ready", 32'(blk_ready), 32'd0);
        end
        hold_rdy = 1'b0;
        t = 0;
        while (hash_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("bp_iv_back", {a0, b0, c0, d0}, IV);
        chk("bp_cnt_zero", 32'(blk_count), 32'd0);
        chk("bp_ready_back", 32'(blk_ready), 32'd1);

        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_err", 32'(err), 32'd1);
        chk("spur_chain", {a0, b0, c0, d0}, IV);
        chk("spur_idle", 32'(blk_ready), 32'd1);
        @(negedge clk);
        chk("spur_no_start", 32'(core_start), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        fix_delay = 8;
        no_hold = 1'b1;
        q_msg.push_back(32'hCAFEF00D);
        q_chain.push_back(IV);
        q_dig.push_back(32'h5A5A5A5A);
        n_exp++;
        drive(32'hCAFEF00D, 1'b1);
        t = 0;
        while (core_start !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rw_start_seen", 32'(core_start), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ns0 = n_starts;
        chk("rw_blk_ready", 32'(blk_ready), 32'd1);
        chk("rw_chain", {a0, b0, c0, d0}, IV);
        chk("rw_err0", 32'(err), 32'd0);
        chk("rw_cnt", 32'(blk_count), 32'd0);
        t = 0;
        while (!err && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("rw_late_done_err", 32'(err), 32'd1);
        chk("rw_chain_after", {a0, b0, c0, d0}, IV);
        repeat (4) @(negedge clk);
        chk("rw_no_start", 32'(n_starts), 32'(ns0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fix_delay = 0;
        no_hold = 1'b0;

        for (int m = 0; m < 30; m++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                issue($urandom, (b == nb - 1), $urandom);
            end
        end
        drain();
        repeat (5) @(negedge clk);
        chk("start_count", 32'(n_starts), 32'(n_exp));
        chk("hash_q_empty", 32'(q_hash.size()), 32'd0);
        chk("msg_q_empty", 32'(q_msg.size()), 32'd0);
        chk("final_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
